// File: rtl/mem_slave_responder.sv
// Single-port storage responder: one write or read per IDLE visit, answered with a registered slv_rsp pulse.
// Optional MEM_RSP_ERR_EN adds rsp_err, flagging out-of-range addresses and wr/rd collisions.
module mem_slave_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  slv_rsp,
`ifdef MEM_RSP_ERR_EN
    output logic                  rsp_err,
`endif
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] SIZE_LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } state_e;

    // Handshake: wr/rd are level strobes sampled only on an edge where the FSM is IDLE;
    // each accepted command is answered by exactly one single-cycle slv_rsp, and strobes
    // seen while busy (RD_WAIT/RSP) are ignored rather than queued.
    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rsp_q;
`ifdef MEM_RSP_ERR_EN
    logic                  err_q;
`endif
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    logic                  cmd_in_range;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Full-width compare so addresses above MEM_SIZE never alias onto low words.
    always_comb begin
        cmd_in_range = {1'b0, addr} < SIZE_LIM;
        mem_we       = (state_q == IDLE) && wr && cmd_in_range;
        rd_addr      = (RD_LATENCY == 1) ? addr : addr_q;
        rd_in_range  = {1'b0, rd_addr} < SIZE_LIM;
        rd_data_d    = rd_in_range ? mem_q[rd_addr[IDX_W-1:0]] : '0;
    end

    // Storage is deliberately not reset; contents survive reset assertion.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr[IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
`ifdef MEM_RSP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr) begin
                        rsp_q   <= 1'b1;
`ifdef MEM_RSP_ERR_EN
                        err_q   <= !cmd_in_range || rd;
`endif
                        state_q <= RSP;
                    end else if (rd) begin
                        addr_q <= addr;
                        if (RD_LATENCY == 1) begin
                            rdata_q <= rd_data_d;
                            rsp_q   <= 1'b1;
`ifdef MEM_RSP_ERR_EN
                            err_q   <= !cmd_in_range;
`endif
                            state_q <= RSP;
                        end else begin
                            cnt_q   <= CNT_W'(RD_LATENCY - 1);
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rdata_q <= rd_data_d;
                        rsp_q   <= 1'b1;
`ifdef MEM_RSP_ERR_EN
                        err_q   <= !rd_in_range;
`endif
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    rsp_q   <= 1'b0;
`ifdef MEM_RSP_ERR_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign slv_rsp   = rsp_q;
    assign state_dbg = state_q;
`ifdef MEM_RSP_ERR_EN
    assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_slave_responder.sv
// Bench for mem_slave_responder: vector table plus hand-built multi-cycle sequences,
// responses checked against a scoreboard queue of {err, rdata} expectations.
module tb_mem_slave_responder;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MS = 16;
    localparam int RL = 2;

    logic          clk;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          slv_rsp;
    logic [1:0]    state_dbg;
`ifdef MEM_RSP_ERR_EN
    logic          rsp_err;
`endif

    mem_slave_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .RD_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .slv_rsp  (slv_rsp),
`ifdef MEM_RSP_ERR_EN
        .rsp_err  (rsp_err),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_count = 0;
    logic prev_rsp = 1'b0;
    logic [DW:0] exp_q[$];
    logic [DW-1:0] model_rdata;
    logic [DW-1:0] model_mem [MS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every slv_rsp pulse pops one expectation
    always @(negedge clk) begin
        logic [DW:0] e;
        if (reset && slv_rsp) begin
            rsp_count++;
            check("single_pulse", 64'(prev_rsp), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got slv_rsp=1 expected no response at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("rdata", 64'(rdata), 64'(e[DW-1:0]));
`ifdef MEM_RSP_ERR_EN
                check("rsp_err", 64'(rsp_err), 64'(e[DW]));
`endif
            end
        end
        prev_rsp = slv_rsp;
    end

    // driver: called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic do_op(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         input logic exp_err, input int exp_lat);
        int lat;
        exp_q.push_back({exp_err, exp_rd});
        wr = w; rd = r; addr = a; wdata = d;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        while (!slv_rsp && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 64'(lat), 64'(exp_lat));
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int base;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        vecs[0]  = '{1'b1, 1'b0, 8'd3,   32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1};
        vecs[1]  = '{1'b0, 1'b1, 8'd3,   32'h0,         32'hDEAD_BEEF, 1'b0, RL};
        vecs[2]  = '{1'b1, 1'b0, 8'd4,   32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[3]  = '{1'b1, 1'b0, 8'd20,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1};
        vecs[4]  = '{1'b0, 1'b1, 8'd20,  32'h0,         32'h0000_0000, 1'b1, RL};
        vecs[5]  = '{1'b0, 1'b1, 8'd4,   32'h0,         32'h0BAD_F00D, 1'b0, RL};
        vecs[6]  = '{1'b1, 1'b1, 8'd7,   32'hA5A5_A5A5, 32'h0BAD_F00D, 1'b1, 1};
        vecs[7]  = '{1'b0, 1'b1, 8'd7,   32'h0,         32'hA5A5_A5A5, 1'b0, RL};
        vecs[8]  = '{1'b1, 1'b0, 8'd15,  32'hCAFE_0001, 32'hA5A5_A5A5, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b1, 8'd15,  32'h0,         32'hCAFE_0001, 1'b0, RL};
        vecs[10] = '{1'b0, 1'b1, 8'd16,  32'h0,         32'h0000_0000, 1'b1, RL};
        vecs[11] = '{1'b1, 1'b0, 8'd0,   32'h0000_0042, 32'h0000_0000, 1'b0, 1};
        vecs[12] = '{1'b0, 1'b1, 8'd0,   32'h0,         32'h0000_0042, 1'b0, RL};
        vecs[13] = '{1'b0, 1'b1, 8'd255, 32'h0,         32'h0000_0000, 1'b1, RL};

        reset = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        model_rdata = '0;

        // reset held for 3 cycles, then idle
        repeat (3) @(negedge clk);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_slv_rsp", 64'(slv_rsp), 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_no_rsp", 64'(slv_rsp), 64'd0);
        end

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
            if (vecs[i].rd && !vecs[i].wr) model_rdata = vecs[i].exp_rdata;
        end

        // write then read strobe raised during RSP: ignored there, taken on next IDLE edge
        base = rsp_count;
        exp_q.push_back({1'b0, model_rdata});
        exp_q.push_back({1'b0, 32'h0000_0001});
        wr = 1'b1; addr = 8'd5; wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        check("held_wr_rsp", 64'(slv_rsp), 64'd1);
        wr = 1'b0; rd = 1'b1; addr = 8'd5;
        @(posedge clk);
        @(negedge clk);
        check("held_rd_ignored_in_rsp", 64'(slv_rsp), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        check("held_rd_waiting", 64'(slv_rsp), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("held_rd_rsp", 64'(slv_rsp), 64'd1);
        repeat (3) @(negedge clk);
        check("held_rsp_count", 64'(rsp_count - base), 64'd2);
        model_rdata = 32'h1;

        // random writes to a scratch region, then random read-back
        for (int i = 0; i < 7; i++) begin
            a = AW'(8 + i);
            d = $urandom;
            model_mem[8 + i] = d;
            do_op(1'b1, 1'b0, a, d, model_rdata, 1'b0, 1);
        end
        for (int i = 0; i < 8; i++) begin
            base = $urandom_range(8, 14);
            a = AW'(base);
            do_op(1'b0, 1'b1, a, '0, model_mem[base], 1'b0, RL);
            model_rdata = model_mem[base];
        end

        // reset during RD_WAIT aborts the read; storage survives
        rd = 1'b1; addr = 8'd3;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_rdata", 64'(rdata), 64'd0);
        check("abort_slv_rsp", 64'(slv_rsp), 64'd0);
        check("abort_state", 64'(state_dbg), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(slv_rsp), 64'd0);
        end
        do_op(1'b0, 1'b1, 8'd3, '0, 32'hDEAD_BEEF, 1'b0, RL);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
